output_interface: RTL and testbench



---
 rtl/output_interface_pkg.sv | 38 +++
 rtl/output_interface_seven_seg_decoder.sv | 18 +
 rtl/output_interface.sv | 128 ++++++++++++
 tb/tb_output_interface.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/output_interface_pkg.sv
// Shared constants for the OUT-port seven-segment display stage.
package output_interface_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low polarity: a 0 lights a segment, decimal point or digit
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       DP_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Hex glyph table, segments ordered {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/output_interface_seven_seg_decoder.sv
// Combinational nibble-to-glyph decoder with a blank override.
module seven_seg_decoder
  import output_interface_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the glyph so leading zeros go dark
  always_comb begin
    seg = hex_seg(nibble);
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/output_interface.sv
// OUT-port latch plus tear-free, time-multiplexed 8-digit hex display driver.
module output_interface
  import output_interface_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        WrEn,
  input  logic [31:0] WrData,
  input  logic        Freeze,
  output logic [31:0] OutValue,
  output logic        Valid,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [7:0]  An
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [31:0]   latch_reg;
  logic          valid_reg;
  logic          run_reg;
  logic [PW-1:0] presc_reg;
  logic [2:0]    index_reg;
  logic [31:0]   shadow_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic [7:0]    an_reg;

  logic          tick;
  logic [7:0]    upper_zero;
  logic [3:0]    cur_nibble;
  logic          cur_blank;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic [7:0]    an_next;

  assign tick = (presc_reg == PRESC_LAST);

  // Architectural latch: the core's OUT-port write, suppressed while frozen
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      latch_reg <= '0;
      valid_reg <= 1'b0;
    end else if (WrEn && !Freeze) begin
      latch_reg <= WrData;
      valid_reg <= 1'b1;
    end
  end

  // The first edge out of reset only arms the scan, so digit 0 first lights
  // on the second edge and still gets a full dwell period
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Digit scan; the shadow snapshot is taken only on the 7->0 wrap so a frame
  // always shows one coherent word (a same-edge write lands next frame)
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      presc_reg  <= '0;
      index_reg  <= '0;
      shadow_reg <= '0;
    end else if (run_reg) begin
      if (tick) begin
        presc_reg <= '0;
        index_reg <= index_reg + 3'd1;
        if (index_reg == 3'd7) begin
          shadow_reg <= latch_reg;
        end
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  // upper_zero[i] is set when nibbles i..7 of the snapshot are all zero
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = ~|shadow_reg[31:4*gi];
    end
  endgenerate

  assign cur_nibble = shadow_reg[{index_reg, 2'b00} +: 4];
  assign cur_blank  = BLANK_LEADING && (index_reg != 3'd0) && upper_zero[index_reg];

  seven_seg_decoder u_decoder (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .seg    (seg_next)
  );

  // Next digit enable and frozen indicator on the leftmost digit
  always_comb begin
    an_next = ~(8'b0000_0001 << index_reg);
    dp_next = DP_OFF;
    if (Freeze && (index_reg == 3'd7)) begin
      dp_next = DP_ON;
    end
  end

  // Registered pin drivers, one cycle behind index/shadow
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      seg_reg <= SEG_BLANK;
      dp_reg  <= DP_OFF;
      an_reg  <= AN_OFF;
    end else if (run_reg) begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign OutValue = latch_reg;
  assign Valid    = valid_reg;
  assign Seg      = seg_reg;
  assign Dp       = dp_reg;
  assign An       = an_reg;

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface with REFRESH_DIV=4, BLANK_LEADING=1.
module tb_output_interface;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        WrEn;
  logic [31:0] WrData;
  logic        Freeze;
  logic [31:0] OutValue;
  logic        Valid;
  logic [6:0]  Seg;
  logic        Dp;
  logic [7:0]  An;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [31:0] exp_out;
  logic [6:0]  exp_seg [0:7];

  output_interface #(
    .REFRESH_DIV   (4),
    .BLANK_LEADING (1'b1)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .WrEn     (WrEn),
    .WrData   (WrData),
    .Freeze   (Freeze),
    .OutValue (OutValue),
    .Valid    (Valid),
    .Seg      (Seg),
    .Dp       (Dp),
    .An       (An)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Steps through one 32-cycle display frame checking every output cycle
  task automatic check_frame(input string tag);
    int d;
    logic [7:0] an_exp;
    for (int i = 0; i < 32; i++) begin
      step();
      WrEn = 1'b0;
      d = i / 4;
      an_exp = 8'hFF;
      an_exp[d] = 1'b0;
      chk({tag, "_an"}, {24'h0, An}, {24'h0, an_exp});
      chk({tag, "_seg"}, {25'h0, Seg}, {25'h0, exp_seg[d]});
      chk({tag, "_dp"}, {31'h0, Dp}, {31'h0, (Freeze && d == 7) ? 1'b0 : 1'b1});
      chk({tag, "_out"}, OutValue, exp_out);
    end
  endtask

  initial begin
    Rst_n  = 1'b0;
    WrEn   = 1'b0;
    WrData = '0;
    Freeze = 1'b0;

    // 1. reset held for 3 edges, then release
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", {24'h0, An}, 32'hFF);
      chk("rst_seg", {25'h0, Seg}, 32'h7F);
      chk("rst_dp", {31'h0, Dp}, 32'h1);
      chk("rst_out", OutValue, 32'h0);
      chk("rst_valid", {31'h0, Valid}, 32'h0);
    end
    Rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rel1_an", {24'h0, An}, 32'hFF);
    step();
    chk("rel2_an", {24'h0, An}, 32'hFE);
    chk("rel2_seg", {25'h0, Seg}, 32'h40);
    wait_to(6);
    chk("rel6_an", {24'h0, An}, 32'hFD);
    chk("rel6_seg", {25'h0, Seg}, 32'h7F);

    // 2. write 0xA5
    WrEn = 1'b1;
    WrData = 32'h0000_00A5;
    step();
    WrEn = 1'b0;
    chk("a5_out", OutValue, 32'h0000_00A5);
    chk("a5_valid", {31'h0, Valid}, 32'h1);
    wait_to(33);
    chk("a5_old_an", {24'h0, An}, 32'h7F);
    chk("a5_old_seg", {25'h0, Seg}, 32'h7F);
    exp_out = 32'h0000_00A5;
    exp_seg = '{7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("a5_frame");

    // 3. back-to-back writes, last one wins
    wait_to(66);
    WrEn = 1'b1;
    WrData = 32'h1234_5678;
    step();
    WrData = 32'hDEAD_BEEF;
    step();
    WrEn = 1'b0;
    chk("b2b_out", OutValue, 32'hDEAD_BEEF);
    wait_to(97);
    exp_out = 32'hDEAD_BEEF;
    exp_seg = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};
    check_frame("dead_frame");

    // 4. frozen write ignored, Dp lit on digit 7 only
    Freeze = 1'b1;
    WrEn = 1'b1;
    WrData = 32'hFFFF_FFFF;
    check_frame("frz_frame");
    chk("frz_valid", {31'h0, Valid}, 32'h1);
    Freeze = 1'b0;
    WrEn = 1'b1;
    WrData = 32'hFFFF_FFFF;
    step();
    WrEn = 1'b0;
    chk("unfrz_out", OutValue, 32'hFFFF_FFFF);
    chk("unfrz_dp", {31'h0, Dp}, 32'h1);

    // 5. write lands on the exact 7->0 wrap edge
    wait_to(192);
    WrEn = 1'b1;
    WrData = 32'h0000_3C0C;
    step();
    WrEn = 1'b0;
    chk("wrap_out", OutValue, 32'h0000_3C0C);
    exp_out = 32'h0000_3C0C;
    exp_seg = '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
    check_frame("wrap_old_frame");
    exp_seg = '{7'h46, 7'h40, 7'h46, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("wrap_new_frame");

    // 6. reset mid-frame (index 5) with a simultaneous write
    wait_to(277);
    chk("mid_an", {24'h0, An}, 32'hEF);
    Rst_n = 1'b0;
    WrEn = 1'b1;
    WrData = 32'h1234_5678;
    step();
    chk("mrst_an", {24'h0, An}, 32'hFF);
    chk("mrst_seg", {25'h0, Seg}, 32'h7F);
    chk("mrst_dp", {31'h0, Dp}, 32'h1);
    chk("mrst_out", OutValue, 32'h0);
    chk("mrst_valid", {31'h0, Valid}, 32'h0);
    Rst_n = 1'b1;
    WrEn = 1'b0;
    cyc = 0;
    step();
    chk("mrel1_an", {24'h0, An}, 32'hFF);
    chk("mrel1_out", OutValue, 32'h0);
    step();
    chk("mrel2_an", {24'h0, An}, 32'hFE);
    chk("mrel2_seg", {25'h0, Seg}, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
